mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning words per cache line (power of two, 2..16).
REQ-002 SHALL have clk  input  1  single rising-edge clock.
REQ-003 SHALL have rst  input  1  synchronous active-high reset.
REQ-004 SHALL have i_req  input  1  I-cache line refill request; held high until i_done.
REQ-005 SHALL have i_addr  input  32  I-cache line base address, line-aligned, stable while i_req.
REQ-006 SHALL have i_rvalid, i_done  output  1 each  read-word strobe and end-of-line pulse to I-cache.
REQ-007 SHALL have d_req, d_wr  input  1 each  D-cache line request and direction (1 = writeback), held until d_done.
REQ-008 SHALL have d_addr  input  32  D-cache line base address, line-aligned.
REQ-009 SHALL have d_wdata  input  32  writeback word selected by d_widx, combinational from D-cache.
REQ-010 SHALL have d_widx  output  log2(WORDS)  index of writeback word currently being issued.
REQ-011 SHALL have d_rvalid, d_done  output  1 each  read-word strobe and end-of-line pulse to D-cache.
REQ-012 SHALL have r_idx  output  log2(WORDS)  word index of current rdata, shared by both requesters.
REQ-013 SHALL have rdata  output  32  returned read word, valid with i_rvalid or d_rvalid.
REQ-014 SHALL have mem_req, mem_wr  output  1 each  memory port request and direction.
REQ-015 SHALL have mem_addr, mem_wdata  output  32 each  word address and write data.
REQ-016 SHALL have mem_addr_ok, mem_data_ok  input  1 each  request accepted / response (read data or write ack) returned.
REQ-017 SHALL have mem_rdata  input  32  read data, valid with mem_data_ok.

Function
REQ-018 SHALL implement states IDLE, GNT_D, GNT_I.
REQ-019 IDLE: d_req only -> GNT_D; i_req only -> GNT_I; both -> the requester not granted last (last_gnt register); transition takes one cycle, mem_req low in IDLE.
REQ-020 Grant SHALL be non-preemptive: a line transaction completes fully before re-arbitration.
REQ-021 In a grant state, mem_req SHALL be high while issue_cnt < WORDS; mem_addr = base + issue_cnt*4; mem_wr = d_wr in GNT_D, 0 in GNT_I.
REQ-022 issue_cnt SHALL increment on mem_req & mem_addr_ok; addresses may run ahead of responses (multiple outstanding).
REQ-023 In GNT_D with d_wr, d_widx SHALL equal issue_cnt and mem_wdata SHALL equal d_wdata; otherwise mem_wdata = 0.
REQ-024 ret_cnt SHALL increment on mem_data_ok; r_idx = ret_cnt, rdata = mem_rdata (combinational pass-through).
REQ-025 i_rvalid = mem_data_ok in GNT_I; d_rvalid = mem_data_ok & ~d_wr in GNT_D; never both.
REQ-026 On mem_data_ok with ret_cnt = WORDS-1, the granted done SHALL pulse for exactly that cycle, next state IDLE, counters cleared, last_gnt updated.
REQ-027 mem_data_ok in IDLE SHALL be ignored (no strobe, no counter change).
REQ-028 Counters SHALL be log2(WORDS)+1 bits so WORDS is representable; no wrap within a line.
REQ-029 Address generation SHALL use base[31:2+log2(WORDS)] concatenated with issue_cnt and 2'b00.
REQ-030 Requester dropping req mid-grant SHALL NOT abort the line; done still pulses.

Reset
REQ-031 On rst: state IDLE, issue_cnt = ret_cnt = 0, last_gnt = I (so D wins first tie), all outputs 0 next cycle.
REQ-032 Reset mid-transaction SHALL abandon the line; later stray mem_data_ok ignored per REQ-027.

Structure
REQ-033 State encoding and WORDS default SHALL live in shared package cpu_defs.
REQ-034 Single flat module; no sub-modules.

Verification
REQ-035 i_req only, addr 0x1FC0_0010, WORDS=4, addr_ok/data_ok every cycle -> mem_addr 0x1FC00010,14,18,1C; 4 i_rvalid with r_idx 0..3; i_done on 4th.
REQ-036 d_req & i_req same cycle after reset -> GNT_D first; after d_done, GNT_I without new tie-break.
REQ-037 d_wr line 0x0000_1000, d_wdata = 0xA0+d_widx -> mem_wdata 0xA0..0xA3 with mem_wr=1; no d_rvalid; d_done on 4th ack.
REQ-038 addr_ok immediate, data_ok delayed 3 cycles -> all 4 addresses issued before first response; mem_req drops at issue_cnt=4.
REQ-039 rst asserted after 2 returned words -> IDLE next cycle, mem_req=0; subsequent data_ok produces no strobes.
REQ-040 Repeated simultaneous requests -> grants alternate D, I, D, I.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU memory-subsystem definitions: arbiter FSM encoding and line geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_defs;

  // Default cache line length in 32-bit words.
  localparam int WORDS_DEFAULT = 4;

  // Arbiter FSM encoding; kept as plain constants so legacy code can compare raw bits.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_D = 2'd1;
  localparam logic [1:0] ST_GNT_I = 2'd2;

  // Encoding of the last-granted requester, used for the round-robin tie-break.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line refills/writebacks onto one word-wide memory port.
// Latency: one IDLE cycle to grant, then words issue back-to-back; responses may lag issue freely.
// Backpressure: issue stalls while mem_addr_ok is low; the grant is held until the last response.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   i_req/i_addr, i_rvalid/i_done   I-cache line read request and per-word/end-of-line strobes
//   d_req/d_wr/d_addr/d_wdata       D-cache line request, direction (1 = writeback), writeback word
//   d_widx                          index of the writeback word the D-cache must present on d_wdata
//   d_rvalid/d_done                 D-cache per-word read strobe and end-of-line pulse
//   r_idx/rdata                     word index and data of the current response (both requesters)
//   mem_*                           memory port: request, direction, word address, write data,
//                                   request accept, response strobe, read data
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [31:0]                i_addr,
  output logic                       i_rvalid,
  output logic                       i_done,
  input  logic                       d_req,
  input  logic                       d_wr,
  input  logic [31:0]                d_addr,
  input  logic [31:0]                d_wdata,
  output logic [$clog2(WORDS)-1:0]   d_widx,
  output logic                       d_rvalid,
  output logic                       d_done,
  output logic [$clog2(WORDS)-1:0]   r_idx,
  output logic [31:0]                rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = IW + 1;
  // Counters carry one extra bit so "all WORDS issued" is distinct from index 0.
  localparam logic [CW-1:0] LINE_WORDS = CW'(WORDS);
  localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);

  logic [1:0]    state;
  logic          lastGnt;
  logic [CW-1:0] issueCnt;
  logic [CW-1:0] retCnt;

  logic          inGntD;
  logic          inGntI;
  logic          granted;
  logic          wrLine;
  logic          lastResp;
  logic [31:0]   baseAddr;
  logic          unusedBaseBits;

  assign inGntD   = (state == ST_GNT_D);
  assign inGntI   = (state == ST_GNT_I);
  assign granted  = inGntD | inGntI;
  assign wrLine   = inGntD & d_wr;
  assign baseAddr = inGntD ? d_addr : i_addr;

  // Line-aligned base: the word-offset bits are replaced by issueCnt.
  assign unusedBaseBits = ^baseAddr[1+IW:0];

  // Issue side: runs ahead of responses until every word of the line is accepted.
  assign mem_req   = granted && (issueCnt != LINE_WORDS);
  assign mem_wr    = mem_req & wrLine;
  assign mem_addr  = mem_req ? {baseAddr[31:2+IW], issueCnt[IW-1:0], 2'b00} : 32'd0;
  assign d_widx    = wrLine ? issueCnt[IW-1:0] : '0;
  assign mem_wdata = (mem_req & wrLine) ? d_wdata : 32'd0;

  // Response side: strobes only while a line is granted, so stray acks after reset are dropped.
  assign lastResp = mem_data_ok && granted && (retCnt == LAST_WORD);
  assign i_rvalid = mem_data_ok & inGntI;
  assign d_rvalid = mem_data_ok & inGntD & ~d_wr;
  assign i_done   = lastResp & inGntI;
  assign d_done   = lastResp & inGntD;
  assign r_idx    = retCnt[IW-1:0];
  assign rdata    = granted ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lastGnt  <= LAST_I;
      issueCnt <= '0;
      retCnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // D wins a tie only if I was served last; otherwise alternate.
          if (d_req && (!i_req || lastGnt == LAST_I)) begin
            state <= ST_GNT_D;
          end else if (i_req) begin
            state <= ST_GNT_I;
          end
        end
        ST_GNT_D, ST_GNT_I: begin
          // Non-preemptive: only the final response ends the grant, even if req drops.
          if (mem_req && mem_addr_ok) begin
            issueCnt <= issueCnt + CW'(1);
          end
          if (mem_data_ok) begin
            if (retCnt == LAST_WORD) begin
              state    <= ST_IDLE;
              lastGnt  <= inGntD ? LAST_D : LAST_I;
              issueCnt <= '0;
              retCnt   <= '0;
            end else begin
              retCnt <= retCnt + CW'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          issueCnt <= '0;
          retCnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus a round-robin sequence.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic        i_done;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_widx;
  logic        d_rvalid;
  logic        d_done;
  logic [1:0]  r_idx;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int nChk  = 0;
  int nMiss = 0;

  mem_arbiter #(.WORDS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rvalid    (i_rvalid),
    .i_done      (i_done),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_widx      (d_widx),
    .d_rvalid    (d_rvalid),
    .d_done      (d_done),
    .r_idx       (r_idx),
    .rdata       (rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  // D-cache writeback data: word k of the line is 0xA0+k.
  assign d_wdata = 32'hA0 + {30'd0, d_widx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iReq, dReq, dWr, addrOk, dataOk;
    logic [31:0] rdIn;
    logic        memReq, memWr;
    logic [31:0] memAddr, memWdata;
    logic        iRv, iDone, dRv, dDone;
    logic [1:0]  rIdx, dWidx;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t v(
    input logic rs, input logic ir, input logic dr, input logic dw,
    input logic ao, input logic dok, input logic [31:0] rin,
    input logic mrq, input logic mwr, input logic [31:0] ma, input logic [31:0] mwd,
    input logic irv, input logic idn, input logic drv, input logic ddn,
    input logic [1:0] ridx, input logic [1:0] widx, input logic [31:0] rd);
    vec_t t;
    t.rst = rs; t.iReq = ir; t.dReq = dr; t.dWr = dw; t.addrOk = ao; t.dataOk = dok;
    t.rdIn = rin; t.memReq = mrq; t.memWr = mwr; t.memAddr = ma; t.memWdata = mwd;
    t.iRv = irv; t.iDone = idn; t.dRv = drv; t.dDone = ddn;
    t.rIdx = ridx; t.dWidx = widx; t.rdata = rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChk++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  localparam int NVEC = 31;
  localparam logic [31:0] IA = 32'h1FC0_0010;
  localparam logic [31:0] DA = 32'h0000_1000;

  vec_t tbl [NVEC];

  initial begin
    // Reset / idle
    tbl[0]  = v(0,0,0,0,0,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    // I-only line, addr_ok and data_ok every cycle
    tbl[1]  = v(0,1,0,0,1,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[2]  = v(0,1,0,0,1,0,32'h0,        1,0,IA,0,           0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[3]  = v(0,1,0,0,1,1,32'h11110000, 1,0,32'h1FC00014,0, 1,0,0,0, 2'd0,2'd0,32'h11110000);
    tbl[4]  = v(0,1,0,0,1,1,32'h11110001, 1,0,32'h1FC00018,0, 1,0,0,0, 2'd1,2'd0,32'h11110001);
    tbl[5]  = v(0,1,0,0,1,1,32'h11110002, 1,0,32'h1FC0001C,0, 1,0,0,0, 2'd2,2'd0,32'h11110002);
    tbl[6]  = v(0,1,0,0,1,1,32'h11110003, 0,0,32'h0,0,        1,1,0,0, 2'd3,2'd0,32'h11110003);
    // Stray response while idle is ignored
    tbl[7]  = v(0,0,0,0,1,1,32'h0000DEAD, 0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    // Reset, then simultaneous D writeback and I read: D first
    tbl[8]  = v(1,0,0,0,0,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[9]  = v(0,1,1,1,1,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[10] = v(0,1,1,1,1,0,32'h0,        1,1,DA,32'hA0,      0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[11] = v(0,1,1,1,1,1,32'h0,        1,1,32'h1004,32'hA1,0,0,0,0, 2'd0,2'd1,32'h0);
    tbl[12] = v(0,1,1,1,1,1,32'h0,        1,1,32'h1008,32'hA2,0,0,0,0, 2'd1,2'd2,32'h0);
    tbl[13] = v(0,1,1,1,1,1,32'h0,        1,1,32'h100C,32'hA3,0,0,0,0, 2'd2,2'd3,32'h0);
    tbl[14] = v(0,1,1,1,1,1,32'h0,        0,0,32'h0,0,        0,0,0,1, 2'd3,2'd0,32'h0);
    // I follows without a new tie-break; responses lag issue by 3 cycles
    tbl[15] = v(0,1,0,0,1,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[16] = v(0,1,0,0,1,0,32'h0,        1,0,IA,0,           0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[17] = v(0,1,0,0,1,0,32'h0,        1,0,32'h1FC00014,0, 0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[18] = v(0,1,0,0,1,0,32'h0,        1,0,32'h1FC00018,0, 0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[19] = v(0,1,0,0,1,1,32'h22220000, 1,0,32'h1FC0001C,0, 1,0,0,0, 2'd0,2'd0,32'h22220000);
    tbl[20] = v(0,1,0,0,1,1,32'h22220001, 0,0,32'h0,0,        1,0,0,0, 2'd1,2'd0,32'h22220001);
    tbl[21] = v(0,1,0,0,1,1,32'h22220002, 0,0,32'h0,0,        1,0,0,0, 2'd2,2'd0,32'h22220002);
    tbl[22] = v(0,1,0,0,1,1,32'h22220003, 0,0,32'h0,0,        1,1,0,0, 2'd3,2'd0,32'h22220003);
    tbl[23] = v(0,0,0,0,1,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    // D read line, reset after two returned words, then stray responses
    tbl[24] = v(0,0,1,0,1,0,32'h0,        0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[25] = v(0,0,1,0,1,0,32'h0,        1,0,DA,0,           0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[26] = v(0,0,1,0,1,1,32'h33330000, 1,0,32'h1004,0,     0,0,1,0, 2'd0,2'd0,32'h33330000);
    tbl[27] = v(0,0,1,0,1,1,32'h33330001, 1,0,32'h1008,0,     0,0,1,0, 2'd1,2'd0,32'h33330001);
    tbl[28] = v(1,0,1,0,1,0,32'h0,        1,0,32'h100C,0,     0,0,0,0, 2'd2,2'd0,32'h0);
    tbl[29] = v(0,0,0,0,1,1,32'h33330002, 0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
    tbl[30] = v(0,0,0,0,1,1,32'h33330003, 0,0,32'h0,0,        0,0,0,0, 2'd0,2'd0,32'h0);
  end

  initial begin
    logic [127:0] act;
    logic [127:0] exp;
    logic         pend;
    logic         order [4];
    int           nDone;
    int           cyc;
    int           iCnt;
    int           dCnt;
    int           both;

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = IA; d_addr = DA;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      rst         = tbl[k].rst;
      i_req       = tbl[k].iReq;
      d_req       = tbl[k].dReq;
      d_wr        = tbl[k].dWr;
      mem_addr_ok = tbl[k].addrOk;
      mem_data_ok = tbl[k].dataOk;
      mem_rdata   = tbl[k].rdIn;
      #1;
      act = {22'd0, mem_req, mem_wr, mem_addr, mem_wdata,
             i_rvalid, i_done, d_rvalid, d_done, r_idx, d_widx, rdata};
      exp = {22'd0, tbl[k].memReq, tbl[k].memWr, tbl[k].memAddr, tbl[k].memWdata,
             tbl[k].iRv, tbl[k].iDone, tbl[k].dRv, tbl[k].dDone,
             tbl[k].rIdx, tbl[k].dWidx, tbl[k].rdata};
      chk($sformatf("vec%0d", k), act, exp);
    end

    // Both requesters held high across four lines: grants must alternate D, I, D, I
    // (state is freshly reset, so D wins the first tie). Memory accepts every
    // address at once and answers one cycle after acceptance.
    @(negedge clk);
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
    pend = 1'b0; nDone = 0; cyc = 0; iCnt = 0; dCnt = 0; both = 0;
    for (int k = 0; k < 4; k++) order[k] = 1'b0;
    while (nDone < 4 && cyc < 200) begin
      @(negedge clk);
      mem_data_ok = pend;
      mem_rdata   = 32'(cyc);
      #1;
      if (i_rvalid) iCnt++;
      if (d_rvalid) dCnt++;
      if (i_rvalid && d_rvalid) both++;
      if (d_done) begin order[nDone] = 1'b1; nDone++; end
      else if (i_done) begin order[nDone] = 1'b0; nDone++; end
      pend = mem_req;
      cyc++;
    end
    chk("rr_lines_done", 128'(nDone), 128'd4);
    chk("rr_grant0_d", {127'd0, order[0]}, 128'd1);
    chk("rr_grant1_i", {127'd0, order[1]}, 128'd0);
    chk("rr_grant2_d", {127'd0, order[2]}, 128'd1);
    chk("rr_grant3_i", {127'd0, order[3]}, 128'd0);
    chk("rr_i_strobes", 128'(iCnt), 128'd8);
    chk("rr_d_strobes", 128'(dCnt), 128'd8);
    chk("rr_no_dual_strobe", 128'(both), 128'd0);

    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nMiss);
    $finish;
  end

endmodule
